// File: rtl/lf_mod_sequencer_pkg.sv
// Shared encoding codes, FSM state codes, rf_div floor and per-bit level helper
// for lf_mod_sequencer.
package lf_mod_sequencer_pkg;

  localparam logic [1:0] ENC_NRZ     = 2'd0;
  localparam logic [1:0] ENC_MANCH   = 2'd1;
  localparam logic [1:0] ENC_BIPHASE = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [7:0] MIN_RF_DIV = 8'd8;

  // Field cycles per bit actually used: LSB dropped, floored at MIN_RF_DIV.
  function automatic logic [7:0] eff_rf_div(input logic [7:0] raw);
    logic [7:0] even;
    even = {raw[7:1], 1'b0};
    return (even < MIN_RF_DIV) ? MIN_RF_DIV : even;
  endfunction

  // Level to drive at a bit start (second_half=0) or at the half-bit point.
  function automatic logic enc_level(input logic [1:0] enc, input logic bit_v,
                                     input logic cur, input logic second_half);
    case (enc)
      ENC_MANCH:   return second_half ? ~bit_v : bit_v;
      ENC_BIPHASE: return (!second_half || !bit_v) ? ~cur : cur;
      default:     return bit_v;
    endcase
  endfunction

endpackage

// File: rtl/lf_edge_detect.sv
// Synchronizes the raw LF field comparator into pck0 and pulses o_edge for one
// cycle on every synchronized rising edge.
module lf_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/lf_mod_sequencer.sv
// LF load-modulation sequencer: serializes bytes MSB first onto mod_out, paced by
// field edges. Optional field-loss abort is built when LF_SEQ_FIELD_TIMEOUT_EN is defined.
//   state | meaning
//   IDLE  | no frame; mod_out low; a byte accepted here starts a frame
//   SEND  | frame in progress; bits advance on synchronized field edges
module lf_mod_sequencer
  import lf_mod_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       pck0,
  input  logic       rst,
  input  logic       cross_lo,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] cfg_enc,
  input  logic [7:0] cfg_rf_div,
  output logic       mod_out,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  if (TIMEOUT_CYC < 2) begin : g_timeout_chk
    $error("lf_mod_sequencer: TIMEOUT_CYC must be at least 2");
  end

  logic [0:0] r_state;
  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic [7:0] r_div;
  logic [7:0] r_edge_cnt;
  logic [1:0] r_enc;
  logic       r_started;
  logic       r_mod;
  logic       r_busy;
  logic       r_done;
  logic       r_abort;

  logic       w_field_edge;
  logic       w_accept;
  logic       w_step;
  logic [7:0] w_cnt_next;
  logic       w_bit_end;
  logic       w_half;
  logic       w_last_bit;
  logic       w_reload;
  logic       w_frame_end;
  logic       w_next_bit;
  logic       w_timeout;

  lf_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .i_clk   (pck0),
    .i_rst   (rst),
    .i_async (cross_lo),
    .o_edge  (w_field_edge)
  );

  assign w_accept    = tx_valid && !r_hold_full;
  assign w_step      = (r_state == ST_SEND) && r_started && w_field_edge;
  assign w_cnt_next  = r_edge_cnt + 8'd1;
  assign w_bit_end   = w_step && (w_cnt_next == r_div);
  assign w_half      = w_step && (w_cnt_next == {1'b0, r_div[7:1]});
  assign w_last_bit  = (r_bit_idx == 3'd7);
  assign w_reload    = w_bit_end && w_last_bit && r_hold_full;
  assign w_frame_end = w_bit_end && w_last_bit && !r_hold_full;
  assign w_next_bit  = w_reload ? r_hold[7] : r_shift[6];

`ifdef LF_SEQ_FIELD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge pck0) begin
    if (rst || (r_state == ST_IDLE)) begin
      r_to_cnt <= '0;
    end else if (w_field_edge) begin
      r_to_cnt <= TO_W'(1);
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Fires so that abort is seen exactly TIMEOUT_CYC cycles after the last edge.
  assign w_timeout = (r_state == ST_SEND) && !w_field_edge &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge pck0) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_div       <= '0;
      r_edge_cnt  <= '0;
      r_enc       <= '0;
      r_started   <= 1'b0;
      r_mod       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;

      if ((r_state == ST_SEND) && w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end else if (w_reload) begin
        r_hold_full <= 1'b0;
      end

      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_state    <= ST_SEND;
          r_shift    <= tx_data;
          r_enc      <= cfg_enc;
          r_div      <= eff_rf_div(cfg_rf_div);
          r_bit_idx  <= '0;
          r_edge_cnt <= '0;
          r_started  <= 1'b0;
          r_mod      <= 1'b0;
          r_busy     <= 1'b1;
        end
      end else if (w_timeout) begin
        r_state     <= ST_IDLE;
        r_shift     <= '0;
        r_hold_full <= 1'b0;
        r_started   <= 1'b0;
        r_mod       <= 1'b0;
        r_busy      <= 1'b0;
        r_abort     <= 1'b1;
      end else if (w_field_edge && !r_started) begin
        r_started  <= 1'b1;
        r_edge_cnt <= '0;
        r_mod      <= enc_level(r_enc, r_shift[7], r_mod, 1'b0);
      end else if (w_frame_end) begin
        r_state   <= ST_IDLE;
        r_started <= 1'b0;
        r_mod     <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
      end else if (w_bit_end) begin
        r_edge_cnt <= '0;
        r_bit_idx  <= r_bit_idx + 3'd1;
        r_shift    <= w_reload ? r_hold : {r_shift[6:0], 1'b0};
        r_mod      <= enc_level(r_enc, w_next_bit, r_mod, 1'b0);
      end else if (w_step) begin
        r_edge_cnt <= w_cnt_next;
        if (w_half) begin
          r_mod <= enc_level(r_enc, r_shift[7], r_mod, 1'b1);
        end
      end
    end
  end

  assign tx_ready = ~r_hold_full;
  assign mod_out  = r_mod;
  assign busy     = r_busy;
  assign done     = r_done;
  assign abort    = r_abort;

endmodule

// File: tb/tb_lf_mod_sequencer.sv
// Directed, table-driven bench for lf_mod_sequencer; the abort sequence follows
// whether LF_SEQ_FIELD_TIMEOUT_EN is defined for the build.
module tb_lf_mod_sequencer;

  logic       pck0 = 1'b0;
  logic       rst = 1'b1;
  logic       cross_lo = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [1:0] cfg_enc = 2'd0;
  logic [7:0] cfg_rf_div = 8'd8;
  logic       mod_out;
  logic       busy;
  logic       done;
  logic       abort;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  always #5 pck0 = ~pck0;

  lf_mod_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYC(1000)) dut (
    .pck0       (pck0),
    .rst        (rst),
    .cross_lo   (cross_lo),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_enc    (cfg_enc),
    .cfg_rf_div (cfg_rf_div),
    .mod_out    (mod_out),
    .busy       (busy),
    .done       (done),
    .abort      (abort)
  );

  always @(negedge pck0) begin
    if (done)  done_cnt++;
    if (abort) abort_cnt++;
  end

  typedef struct {
    logic [1:0] enc;
    logic [7:0] rf_div;
    int         div_eff;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    int         period;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pck0);
  endtask

  task automatic field_period(input int period);
    cross_lo = 1'b1;
    cyc(period / 2);
    cross_lo = 1'b0;
    cyc(period - period / 2);
  endtask

  // Expected mod_out after field edge k (k=0 starts the first bit), data MSB first.
  function automatic logic exp_mod(input logic [1:0] enc, input logic [15:0] bits,
                                   input int div, input int k);
    logic lvl;
    logic b;
    int   j;
    int   c;
    lvl = 1'b0;
    for (int e = 0; e <= k; e++) begin
      j = e / div;
      c = e % div;
      b = bits[15 - j];
      if (enc == 2'd1)      lvl = (c >= div / 2) ? ~b : b;
      else if (enc == 2'd2) begin
        if (c == 0 || (c == div / 2 && !b)) lvl = ~lvl;
      end
      else                  lvl = b;
    end
    return lvl;
  endfunction

  vec_t vecs[6];

  initial begin
    int d0;
    int a0;
    int total;
    logic [15:0] bits;

    vecs[0] = '{enc: 2'd0, rf_div: 8'd32, div_eff: 32, nbytes: 1, b0: 8'hA5, b1: 8'h00, period: 192};
    vecs[1] = '{enc: 2'd1, rf_div: 8'd16, div_eff: 16, nbytes: 1, b0: 8'h80, b1: 8'h00, period: 16};
    vecs[2] = '{enc: 2'd2, rf_div: 8'd8,  div_eff: 8,  nbytes: 1, b0: 8'h0F, b1: 8'h00, period: 16};
    vecs[3] = '{enc: 2'd0, rf_div: 8'd8,  div_eff: 8,  nbytes: 2, b0: 8'h12, b1: 8'h34, period: 16};
    vecs[4] = '{enc: 2'd3, rf_div: 8'd3,  div_eff: 8,  nbytes: 1, b0: 8'h5A, b1: 8'h00, period: 16};
    vecs[5] = '{enc: 2'd2, rf_div: 8'd17, div_eff: 16, nbytes: 2, b0: 8'hC3, b1: 8'h5A, period: 16};

    cyc(3);
    check("reset mod_out", mod_out, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset abort", abort, 0);
    check("reset tx_ready", tx_ready, 1);
    rst = 1'b0;
    cyc(2);

    for (int v = 0; v < 6; v++) begin
      cfg_enc    = vecs[v].enc;
      cfg_rf_div = vecs[v].rf_div;
      tx_data    = vecs[v].b0;
      tx_valid   = 1'b1;
      cyc(1);
      if (vecs[v].nbytes == 2) begin
        tx_data = vecs[v].b1;
        cyc(1);
      end
      tx_valid   = 1'b0;
      cfg_enc    = vecs[v].enc ^ 2'b01;
      cfg_rf_div = 8'd200;
      check($sformatf("v%0d busy at start", v), busy, 1);
      check($sformatf("v%0d tx_ready at start", v), tx_ready, (vecs[v].nbytes == 2) ? 0 : 1);
      cyc(5);
      check($sformatf("v%0d mod_out before first edge", v), mod_out, 0);
      d0    = done_cnt;
      total = 8 * vecs[v].nbytes * vecs[v].div_eff;
      bits  = {vecs[v].b0, vecs[v].b1};
      for (int k = 0; k < total; k++) begin
        field_period(vecs[v].period);
        check($sformatf("v%0d edge %0d mod_out", v, k), mod_out,
              exp_mod(vecs[v].enc, bits, vecs[v].div_eff, k));
        if (vecs[v].nbytes == 2 && k == 8 * vecs[v].div_eff - 1)
          check($sformatf("v%0d tx_ready while holding full", v), tx_ready, 0);
        if (vecs[v].nbytes == 2 && k == 8 * vecs[v].div_eff)
          check($sformatf("v%0d tx_ready after reload", v), tx_ready, 1);
        if (k == total - 1)
          check($sformatf("v%0d busy in last bit", v), busy, 1);
      end
      field_period(vecs[v].period);
      check($sformatf("v%0d mod_out after frame", v), mod_out, 0);
      check($sformatf("v%0d busy after frame", v), busy, 0);
      cyc(2);
      check($sformatf("v%0d done pulses", v), done_cnt - d0, 1);
      check($sformatf("v%0d tx_ready idle", v), tx_ready, 1);
    end

    // Reset in the middle of a bit of the third byte.
    cfg_enc    = 2'd0;
    cfg_rf_div = 8'd8;
    tx_data    = 8'h12;
    tx_valid   = 1'b1;
    cyc(1);
    tx_data = 8'h34;
    cyc(1);
    tx_valid = 1'b0;
    for (int k = 0; k <= 64; k++) field_period(16);
    check("rst seq tx_ready after first reload", tx_ready, 1);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    check("rst seq third byte held", tx_ready, 0);
    for (int k = 65; k <= 157; k++) field_period(16);
    check("rst seq mod_out in byte 3", mod_out, 1);
    check("rst seq busy in byte 3", busy, 1);
    d0 = done_cnt;
    cross_lo = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("rst seq mod_out", mod_out, 0);
    check("rst seq busy", busy, 0);
    check("rst seq tx_ready", tx_ready, 1);
    check("rst seq abort", abort, 0);
    rst      = 1'b0;
    cross_lo = 1'b0;
    cyc(4);
    check("rst seq no done", done_cnt - d0, 0);
    check("rst seq stays idle", busy, 0);

    // Field stops mid-frame.
    cfg_enc    = 2'd0;
    cfg_rf_div = 8'd8;
    tx_data    = 8'hFF;
    tx_valid   = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    for (int k = 0; k < 5; k++) field_period(16);
    check("stall mod_out before stop", mod_out, 1);
    d0 = done_cnt;
    a0 = abort_cnt;
`ifdef LF_SEQ_FIELD_TIMEOUT_EN
    cross_lo = 1'b1;
    cyc(8);
    cross_lo = 1'b0;
    cyc(993);
    check("timeout abort not early", abort, 0);
    check("timeout busy before abort", busy, 1);
    cyc(1);
    check("timeout abort pulse", abort, 1);
    check("timeout mod_out", mod_out, 0);
    check("timeout busy", busy, 0);
    cyc(1);
    check("timeout abort one cycle", abort, 0);
    cyc(3);
    check("timeout abort count", abort_cnt - a0, 1);
    check("timeout no done", done_cnt - d0, 0);
    check("timeout tx_ready", tx_ready, 1);
`else
    cyc(1200);
    check("no-timeout busy held", busy, 1);
    check("no-timeout mod_out held", mod_out, 1);
    check("no-timeout abort count", abort_cnt - a0, 0);
    check("no-timeout no done", done_cnt - d0, 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("no-timeout cleanup busy", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
